assert_enable_sched: RTL and testbench

- Run-time scheduler for embedded checker enables. It plays the role of $assertoff/$asserton in synthesizable or emulation-friendly form.
- Holds all N_CHK checkers disabled through DUT reset and a settle window, then arms them under a per-checker mask.
- Counts gated failures, captures the first failure (id and cycle), and halts all checking with a stop request once the error budget is exhausted.
- Sits between the testbench/DUT reset sequencer and the array of checker instances.

---
 rtl/assert_enable_sched.sv | 155 +++++++++++++++
 tb/tb_assert_enable_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/assert_enable_sched.sv
// Run-time enable scheduler for embedded checkers: holds checkers off through
// DUT reset and a settle window, arms them under a mask, and halts on an error budget.
module assert_enable_sched #(
  parameter int unsigned N_CHK         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_ERR       = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned ID_W          = $clog2(N_CHK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dut_rst_done,
  input  logic             cfg_mask_we,
  input  logic [N_CHK-1:0] cfg_mask_wdata,
  input  logic             clr_errors,
  input  logic [N_CHK-1:0] chk_fail,
  output logic [N_CHK-1:0] chk_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [ID_W-1:0]  first_fail_id,
  output logic [31:0]      first_fail_cyc,
  output logic             stop_req
);

  localparam int unsigned ST_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned PC_W  = $clog2(N_CHK + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_ARMED  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ST_W-1:0]    settle_q, settle_d;
  logic [N_CHK-1:0]   mask_q, mask_d;
  logic [N_CHK-1:0]   chk_en_q, chk_en_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               ff_vld_q, ff_vld_d;
  logic [ID_W-1:0]    ff_id_q, ff_id_d;
  logic [31:0]        ff_cyc_q, ff_cyc_d;
  logic [31:0]        cyc_q;
  logic               stop_q, stop_d;

  logic [N_CHK-1:0]   gated;
  logic [PC_W-1:0]    pop;
  logic [ID_W-1:0]    low_id;
  logic               found;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   err_sat;

  // Gated failures: popcount and lowest set index of this cycle's vector.
  always_comb begin
    gated  = '0;
    pop    = '0;
    low_id = '0;
    found  = 1'b0;
    if (state_q == S_ARMED) gated = chk_fail & chk_en_q;
    for (int unsigned i = 0; i < N_CHK; i++) begin
      pop = pop + PC_W'(gated[i]);
      if (gated[i] && !found) begin
        low_id = ID_W'(i);
        found  = 1'b1;
      end
    end
    sum     = {1'b0, err_q} + SUM_W'(pop);
    err_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    mask_d   = cfg_mask_we ? cfg_mask_wdata : mask_q;
    err_d    = err_q;
    ff_vld_d = ff_vld_q;
    ff_id_d  = ff_id_q;
    ff_cyc_d = ff_cyc_q;

    case (state_q)
      S_OFF: begin
        if (dut_rst_done) begin
          settle_d = ST_W'(SETTLE_CYCLES);
          state_d  = (SETTLE_CYCLES == 0) ? S_ARMED : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!dut_rst_done)       state_d  = S_OFF;
        else if (settle_q == '0) state_d  = S_ARMED;
        else                     settle_d = settle_q - 1'b1;
      end
      S_ARMED: begin
        err_d = err_sat;
        if (!ff_vld_q && found) begin
          ff_vld_d = 1'b1;
          ff_id_d  = low_id;
          ff_cyc_d = cyc_q;
        end
        if (err_sat >= CNT_W'(MAX_ERR)) state_d = S_HALTED;
        else if (!dut_rst_done)         state_d = S_OFF;
      end
      default: ;
    endcase

    // Clear overrides this cycle's counting, including any halt it would cause.
    if (clr_errors) begin
      err_d    = '0;
      ff_vld_d = 1'b0;
      ff_id_d  = '0;
      ff_cyc_d = '0;
      if (state_q == S_ARMED || state_q == S_HALTED)
        state_d = dut_rst_done ? S_ARMED : S_OFF;
    end

    chk_en_d = (state_d == S_ARMED) ? ~mask_d : '0;
    stop_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      settle_q <= '0;
      mask_q   <= '0;
      chk_en_q <= '0;
      err_q    <= '0;
      ff_vld_q <= 1'b0;
      ff_id_q  <= '0;
      ff_cyc_q <= '0;
      cyc_q    <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      chk_en_q <= chk_en_d;
      err_q    <= err_d;
      ff_vld_q <= ff_vld_d;
      ff_id_q  <= ff_id_d;
      ff_cyc_q <= ff_cyc_d;
      cyc_q    <= cyc_q + 32'd1;
      stop_q   <= stop_d;
    end
  end

  assign chk_en         = chk_en_q;
  assign state          = state_q;
  assign err_cnt        = err_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_id  = ff_id_q;
  assign first_fail_cyc = ff_cyc_q;
  assign stop_req       = stop_q;

endmodule

// File: tb/tb_assert_enable_sched.sv
// Directed bench for assert_enable_sched: default instance (settle 16) and a
// zero-settle instance sharing clock, reset and checker inputs.
module tb_assert_enable_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drd0 = 1'b0, drd1 = 1'b0;
  logic        mask_we = 1'b0;
  logic [7:0]  mask_wd = '0;
  logic        clr = 1'b0;
  logic [7:0]  fail = '0;

  logic [7:0]  en0, en1;
  logic [1:0]  st0, st1;
  logic [15:0] err0, err1;
  logic        vld0, vld1;
  logic [2:0]  id0, id1;
  logic [31:0] fcyc0, fcyc1;
  logic        stop0, stop1;

  int unsigned tbcyc;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tbcyc <= 0;
    else     tbcyc <= tbcyc + 1;
  end

  assert_enable_sched #(.N_CHK(8), .SETTLE_CYCLES(16), .MAX_ERR(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .dut_rst_done(drd0), .cfg_mask_we(mask_we),
    .cfg_mask_wdata(mask_wd), .clr_errors(clr), .chk_fail(fail), .chk_en(en0),
    .state(st0), .err_cnt(err0), .first_fail_vld(vld0), .first_fail_id(id0),
    .first_fail_cyc(fcyc0), .stop_req(stop0));

  assert_enable_sched #(.N_CHK(8), .SETTLE_CYCLES(0), .MAX_ERR(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .dut_rst_done(drd1), .cfg_mask_we(mask_we),
    .cfg_mask_wdata(mask_wd), .clr_errors(clr), .chk_fail(fail), .chk_en(en1),
    .state(st1), .err_cnt(err1), .first_fail_vld(vld1), .first_fail_id(id1),
    .first_fail_cyc(fcyc1), .stop_req(stop1));

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++; if (st0 !== 2'd0)     begin n_fail++; $display("FAIL reset_state got %0d exp 0", st0); end
    n_chk++; if (en0 !== 8'h00)    begin n_fail++; $display("FAIL reset_en got %h exp 00", en0); end
    n_chk++; if (err0 !== 16'd0)   begin n_fail++; $display("FAIL reset_err got %0d exp 0", err0); end
    n_chk++; if (vld0 !== 1'b0 || id0 !== 3'd0 || fcyc0 !== 32'd0)
                                   begin n_fail++; $display("FAIL reset_capture got %b/%0d/%0d exp 0/0/0", vld0, id0, fcyc0); end
    n_chk++; if (stop0 !== 1'b0)   begin n_fail++; $display("FAIL reset_stop got %b exp 0", stop0); end
    rst = 1'b0;
  endtask

  task automatic test_settle();
    while (tbcyc < 4) step();
    drd0 = 1'b1;                                   // sampled at the edge into cycle 5
    step();
    n_chk++; if (st0 !== 2'd1) begin n_fail++; $display("FAIL settle_state got %0d exp 1", st0); end
    while (tbcyc < 22) begin
      fail = (tbcyc == 10) ? 8'h01 : 8'h00;
      n_chk++; if (en0 !== 8'h00) begin n_fail++; $display("FAIL settle_en cyc %0d got %h exp 00", tbcyc, en0); end
      step();
    end
    fail = 8'h00;
    n_chk++; if (en0 !== 8'hFF)  begin n_fail++; $display("FAIL armed_en cyc %0d got %h exp FF", tbcyc, en0); end
    n_chk++; if (st0 !== 2'd2)   begin n_fail++; $display("FAIL armed_state got %0d exp 2", st0); end
    n_chk++; if (err0 !== 16'd0 || vld0 !== 1'b0)
                                 begin n_fail++; $display("FAIL settle_fail_ignored got err %0d vld %b exp 0 0", err0, vld0); end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wd = 8'h0C;
    step();
    mask_we = 1'b0;
    n_chk++; if (en0 !== 8'hF3) begin n_fail++; $display("FAIL mask_en got %h exp F3", en0); end
    while (tbcyc < 39) step();
    fail = 8'h0C;
    step();
    fail = 8'h10;
    step();
    fail = 8'h00;
    n_chk++; if (err0 !== 16'd1)   begin n_fail++; $display("FAIL mask_err got %0d exp 1", err0); end
    n_chk++; if (vld0 !== 1'b1 || id0 !== 3'd4)
                                   begin n_fail++; $display("FAIL mask_id got %b/%0d exp 1/4", vld0, id0); end
    n_chk++; if (fcyc0 !== 32'd40) begin n_fail++; $display("FAIL mask_cyc got %0d exp 40", fcyc0); end
  endtask

  task automatic test_halt();
    mask_we = 1'b1; mask_wd = 8'h00; clr = 1'b1;
    step();
    mask_we = 1'b0; clr = 1'b0;
    n_chk++; if (err0 !== 16'd0 || vld0 !== 1'b0 || fcyc0 !== 32'd0)
                                 begin n_fail++; $display("FAIL clr_armed got %0d/%b/%0d exp 0/0/0", err0, vld0, fcyc0); end
    n_chk++; if (en0 !== 8'hFF)  begin n_fail++; $display("FAIL unmask_en got %h exp FF", en0); end
    fail = 8'h0F;
    step();
    fail = 8'h00;
    n_chk++; if (err0 !== 16'd4) begin n_fail++; $display("FAIL halt_err got %0d exp 4", err0); end
    n_chk++; if (id0 !== 3'd0 || vld0 !== 1'b1)
                                 begin n_fail++; $display("FAIL halt_id got %b/%0d exp 1/0", vld0, id0); end
    n_chk++; if (st0 !== 2'd3 || stop0 !== 1'b1 || en0 !== 8'h00)
                                 begin n_fail++; $display("FAIL halt_state got %0d/%b/%h exp 3/1/00", st0, stop0, en0); end
    drd0 = 1'b0; fail = 8'hFF;
    step();
    n_chk++; if (st0 !== 2'd3 || err0 !== 16'd4)
                                 begin n_fail++; $display("FAIL halt_sticky got %0d/%0d exp 3/4", st0, err0); end
    drd0 = 1'b1; fail = 8'h00; clr = 1'b1;
    step();
    clr = 1'b0;
    n_chk++; if (st0 !== 2'd2 || stop0 !== 1'b0 || en0 !== 8'hFF || err0 !== 16'd0)
                                 begin n_fail++; $display("FAIL halt_clr got %0d/%b/%h/%0d exp 2/0/FF/0", st0, stop0, en0, err0); end
    fail = 8'h01; clr = 1'b1;
    step();
    fail = 8'h00; clr = 1'b0;
    n_chk++; if (err0 !== 16'd0 || vld0 !== 1'b0 || st0 !== 2'd2)
                                 begin n_fail++; $display("FAIL clr_wins got %0d/%b/%0d exp 0/0/2", err0, vld0, st0); end
  endtask

  task automatic test_reset_in_halt();
    fail = 8'h0F;
    step();
    fail = 8'h00;
    mask_we = 1'b1; mask_wd = 8'h0C;
    step();
    mask_we = 1'b0;
    n_chk++; if (st0 !== 2'd3 || err0 !== 16'd4)
                                 begin n_fail++; $display("FAIL rehalt got %0d/%0d exp 3/4", st0, err0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (st0 !== 2'd0 || en0 !== 8'h00 || err0 !== 16'd0 || stop0 !== 1'b0)
                                 begin n_fail++; $display("FAIL rst_halt got %0d/%h/%0d/%b exp 0/00/0/0", st0, en0, err0, stop0); end
    n_chk++; if (vld0 !== 1'b0 || id0 !== 3'd0 || fcyc0 !== 32'd0)
                                 begin n_fail++; $display("FAIL rst_halt_capture got %b/%0d/%0d exp 0/0/0", vld0, id0, fcyc0); end
    for (int i = 0; i < 30 && st0 != 2'd2; i++) step();
    n_chk++; if (st0 !== 2'd2 || tbcyc != 18)
                                 begin n_fail++; $display("FAIL rearm got state %0d cyc %0d exp 2 18", st0, tbcyc); end
    n_chk++; if (en0 !== 8'hFF)  begin n_fail++; $display("FAIL rst_mask got %h exp FF", en0); end
  endtask

  task automatic test_drop();
    fail = 8'h03;
    step();
    fail = 8'h00;
    n_chk++; if (err0 !== 16'd2) begin n_fail++; $display("FAIL drop_pre_err got %0d exp 2", err0); end
    drd0 = 1'b0;
    step();
    n_chk++; if (st0 !== 2'd0 || en0 !== 8'h00 || err0 !== 16'd2)
                                 begin n_fail++; $display("FAIL drop got %0d/%h/%0d exp 0/00/2", st0, en0, err0); end
  endtask

  task automatic test_zero_settle();
    n_chk++; if (st1 !== 2'd0 || err1 !== 16'd0)
                                 begin n_fail++; $display("FAIL z_off got %0d/%0d exp 0/0", st1, err1); end
    drd1 = 1'b1;
    step();
    n_chk++; if (st1 !== 2'd2 || en1 !== 8'hFF)
                                 begin n_fail++; $display("FAIL z_arm got %0d/%h exp 2/FF", st1, en1); end
    fail = 8'h03;
    step();
    fail = 8'h00;
    n_chk++; if (err1 !== 16'd2 || err0 !== 16'd2)
                                 begin n_fail++; $display("FAIL z_err got %0d (u0 %0d) exp 2 (2)", err1, err0); end
    drd1 = 1'b0;
    step();
    n_chk++; if (st1 !== 2'd0 || en1 !== 8'h00 || err1 !== 16'd2)
                                 begin n_fail++; $display("FAIL z_drop got %0d/%h/%0d exp 0/00/2", st1, en1, err1); end
    drd1 = 1'b1;
    step();
    n_chk++; if (st1 !== 2'd2 || en1 !== 8'hFF || err1 !== 16'd2)
                                 begin n_fail++; $display("FAIL z_rearm got %0d/%h/%0d exp 2/FF/2", st1, en1, err1); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_mask();
    test_halt();
    test_reset_in_halt();
    test_drop();
    test_zero_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
